// File: rtl/spi_cmd_receiver.sv
// SPI slave receive path with command/payload framer and output FIFO.
// Optional SPI_RX_STATS_EN adds saturating rx_words / drop_count ports.
module spi_cmd_receiver #(
    parameter int              DATA_W      = 8,
    parameter int              IDX_W       = 16,
    parameter int              SYNC_STAGES = 2,
    parameter int              CPOL        = 0,
    parameter int              CPHA        = 0,
    parameter int              FIFO_DEPTH  = 4,
    parameter logic [DATA_W-1:0] CMD0_CODE = 'h01,
    parameter int              CMD0_LEN    = 513,
    parameter logic [DATA_W-1:0] CMD1_CODE = 'h02,
    parameter int              CMD1_LEN    = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sck,
    input  logic              mosi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_cmd,
    output logic [DATA_W-1:0] out_cmd,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              overflow,
    output logic              frame_error
`ifdef SPI_RX_STATS_EN
    ,
    output logic [31:0]       rx_words,
    output logic [15:0]       drop_count
`endif
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + 2 * DATA_W + IDX_W;
    localparam logic IDLE = (CPOL != 0);
    localparam logic [0:0] ST_CMD  = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;
    localparam logic [IDX_W:0] LEN0 = (IDX_W + 1)'(CMD0_LEN);
    localparam logic [IDX_W:0] LEN1 = (IDX_W + 1)'(CMD1_LEN);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (CMD0_LEN < 0 || (CMD0_LEN >> (IDX_W + 1)) != 0) begin : g_chk_len0
        $error("CMD0_LEN does not fit IDX_W+1 bits");
    end
    if (CMD1_LEN < 0 || (CMD1_LEN >> (IDX_W + 1)) != 0) begin : g_chk_len1
        $error("CMD1_LEN does not fit IDX_W+1 bits");
    end

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_s, cs_s, mosi_s, sck_d, cs_d, armed;
    logic sample, cs_rise, word_done;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // cs_n sync resets low so a select held low through reset never arms
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync  <= {SYNC_STAGES{IDLE}};
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= IDLE;
            cs_d      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            if (cs_s) armed <= 1'b1;
        end
    end

    assign cs_rise = cs_s && !cs_d;
    assign sample  = armed && !cs_s &&
                     ((CPOL == CPHA) ? (sck_s && !sck_d) : (!sck_s && sck_d));

    logic [DATA_W-1:0] shift, word;
    logic [CW-1:0]     bit_cnt;

    assign word      = {shift[DATA_W-2:0], mosi_s};
    assign word_done = sample && (bit_cnt == CW'(DATA_W - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (cs_rise) begin
            bit_cnt <= '0;
        end else if (sample) begin
            shift   <= word;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
    end

    logic [0:0]        state;
    logic [DATA_W-1:0] cur_cmd;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W:0]    remaining, len;
    logic [EW-1:0]     entry;

    always_comb begin
        len = '0;
        if (word == CMD0_CODE) len = LEN0;
        else if (word == CMD1_CODE) len = LEN1;
        if (state == ST_CMD) entry = {1'b1, word, {IDX_W{1'b0}}, word};
        else entry = {1'b0, cur_cmd, idx, word};
    end

    // framing advances on every word, kept or dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_CMD;
            cur_cmd     <= '0;
            idx         <= '0;
            remaining   <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= cs_rise && (bit_cnt != '0 || state == ST_DATA);
            if (cs_rise) begin
                state <= ST_CMD;
            end else if (word_done) begin
                if (state == ST_CMD) begin
                    if (len != '0) begin
                        state     <= ST_DATA;
                        remaining <= len;
                        idx       <= '0;
                        cur_cmd   <= word;
                    end
                end else begin
                    idx       <= idx + IDX_W'(1);
                    remaining <= remaining - (IDX_W + 1)'(1);
                    if (remaining == (IDX_W + 1)'(1)) state <= ST_CMD;
                end
            end
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, pop, accept, drop;
    logic [EW-1:0] head;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = out_valid && out_ready;
    assign accept = word_done && (!full || pop);
    assign drop   = word_done && full && !pop;
    assign head   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
            overflow <= drop;
        end
    end

    assign out_valid = !empty;
    assign {out_is_cmd, out_cmd, out_index, out_data} = out_valid ? head : '0;

`ifdef SPI_RX_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_words   <= '0;
            drop_count <= '0;
        end else begin
            if (word_done && rx_words != '1) rx_words <= rx_words + 32'd1;
            if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Scoreboard bench: mode 0 instance for framing/overflow/cs tests,
// mode 3 instance for sampling edge and full-FIFO pop+push.
module tb_spi_cmd_receiver;

    localparam int H = 30;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic mosi = 1'b0;
    logic cs0_n, sck0, ready0, v0, c0, of0, fe0;
    logic cs3_n, sck3, ready3, v3, c3, of3, fe3;
    logic [7:0]  cmd0, d0, cmd3, d3;
    logic [15:0] ix0, ix3;
`ifdef SPI_RX_STATS_EN
    logic [31:0] rxw0, rxw3;
    logic [15:0] drp0, drp3;
`endif

    spi_cmd_receiver dut0 (
        .clock(clock), .reset(reset), .cs_n(cs0_n), .sck(sck0), .mosi(mosi),
        .out_valid(v0), .out_ready(ready0), .out_is_cmd(c0), .out_cmd(cmd0),
        .out_index(ix0), .out_data(d0), .overflow(of0), .frame_error(fe0)
`ifdef SPI_RX_STATS_EN
        , .rx_words(rxw0), .drop_count(drp0)
`endif
    );

    spi_cmd_receiver #(.CPOL(1), .CPHA(1)) dut3 (
        .clock(clock), .reset(reset), .cs_n(cs3_n), .sck(sck3), .mosi(mosi),
        .out_valid(v3), .out_ready(ready3), .out_is_cmd(c3), .out_cmd(cmd3),
        .out_index(ix3), .out_data(d3), .overflow(of3), .frame_error(fe3)
`ifdef SPI_RX_STATS_EN
        , .rx_words(rxw3), .drop_count(drp3)
`endif
    );

    typedef struct packed {
        logic        is_cmd;
        logic [7:0]  cmd;
        logic [15:0] idx;
        logic [7:0]  data;
    } ent_t;

    ent_t q0[$];
    ent_t q3[$];
    int n_cmp = 0, n_bad = 0;
    int ovf0 = 0, ovf3 = 0, fec0 = 0, fec3 = 0, got3 = 0, words0 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin : mon0
        ent_t g, e;
        if (of0) ovf0++;
        if (fe0) fec0++;
        if (v0 && ready0) begin
            g = {c0, cmd0, ix0, d0};
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL head0: got %h expected none", g);
            end else begin
                e = q0.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL head0: got %h expected %h", g, e);
                end
            end
        end
    end

    always @(negedge clock) begin : mon3
        ent_t g, e;
        if (of3) ovf3++;
        if (fe3) fec3++;
        if (v3 && ready3) begin
            g = {c3, cmd3, ix3, d3};
            got3++;
            n_cmp++;
            if (q3.size() == 0) begin
                n_bad++;
                $display("FAIL head3: got %h expected none", g);
            end else begin
                e = q3.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL head3: got %h expected %h", g, e);
                end
            end
        end
    end

    task automatic spi(input logic [7:0] b, input int nb, input bit m3);
        for (int i = 0; i < nb; i++) begin
            if (!m3) begin
                mosi = b[7-i];
                #H sck0 = 1'b1;
                #H sck0 = 1'b0;
            end else begin
                sck3 = 1'b0;
                mosi = b[7-i];
                #H sck3 = 1'b1;
                #H;
            end
        end
    endtask

    task automatic send0(input logic [7:0] b);
        words0++;
        spi(b, 8, 1'b0);
    endtask

    function automatic void exp0(input bit ic, input logic [7:0] c,
                                 input logic [15:0] i, input logic [7:0] d);
        q0.push_back({ic, c, i, d});
    endfunction

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((q0.size() != 0 || q3.size() != 0) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        chk(nm, 32'(q0.size() + q3.size()), 32'd0);
    endtask

    task automatic set_rdy(input bit r0, input bit r3);
        @(posedge clock);
        #1;
        ready0 = r0;
        ready3 = r3;
    endtask

    initial begin
        cs0_n = 1'b0; sck0 = 1'b0; ready0 = 1'b1;
        cs3_n = 1'b1; sck3 = 1'b1; ready3 = 1'b1;
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_is_cmd", 32'(c0), 32'd0);
        chk("rst_cmd", 32'(cmd0), 32'd0);
        chk("rst_index", 32'(ix0), 32'd0);
        chk("rst_data", 32'(d0), 32'd0);
        chk("rst_ovf", 32'(of0), 32'd0);
        chk("rst_fe", 32'(fe0), 32'd0);
        chk("rst_valid3", 32'(v3), 32'd0);

        spi(8'h01, 8, 1'b0);
        repeat (10) @(negedge clock);
        chk("unarmed_valid", 32'(v0), 32'd0);
        cs0_n = 1'b1;
        #(2 * H);
        chk("unarmed_fe", 32'(fec0), 32'd0);
        cs0_n = 1'b0;
        #H;

        exp0(1, 8'h01, 0, 8'h01);
        for (int i = 0; i < 513; i++) exp0(0, 8'h01, 16'(i), 8'(i));
        send0(8'h01);
        for (int i = 0; i < 513; i++) send0(8'(i));
        drain("drain_cmd01");

        exp0(1, 8'h02, 0, 8'h02);
        for (int i = 0; i < 6; i++) exp0(0, 8'h02, 16'(i), 8'h20 + 8'(i));
        exp0(1, 8'h7F, 0, 8'h7F);
        send0(8'h02);
        for (int i = 0; i < 6; i++) send0(8'h20 + 8'(i));
        send0(8'h7F);
        drain("drain_cmd02");

        set_rdy(1'b0, 1'b1);
        exp0(1, 8'h02, 0, 8'h02);
        for (int i = 0; i < 3; i++) exp0(0, 8'h02, 16'(i), 8'h10 + 8'(i));
        send0(8'h02);
        for (int i = 0; i < 6; i++) send0(8'h10 + 8'(i));
        #(2 * H);
        chk("ovf_pulses", 32'(ovf0), 32'd3);
        chk("hold_valid", 32'(v0), 32'd1);
        chk("hold_cmd", 32'(cmd0), 32'h02);
        chk("hold_is_cmd", 32'(c0), 32'd1);
        set_rdy(1'b1, 1'b1);
        drain("drain_ovf");
        exp0(1, 8'h7F, 0, 8'h7F);
        send0(8'h7F);
        drain("drain_after_ovf");

        exp0(1, 8'h02, 0, 8'h02);
        exp0(0, 8'h02, 0, 8'h33);
        send0(8'h02);
        send0(8'h33);
        spi(8'h44, 3, 1'b0);
        cs0_n = 1'b1;
        #(2 * H);
        chk("fe_midword", 32'(fec0), 32'd1);
        cs0_n = 1'b0;
        #H;
        exp0(1, 8'h01, 0, 8'h01);
        send0(8'h01);
        #(2 * H);
        cs0_n = 1'b1;
        #(2 * H);
        chk("fe_in_data", 32'(fec0), 32'd2);
        drain("drain_fe");
        cs0_n = 1'b0;
        #H;

        set_rdy(1'b1, 1'b0);
        cs3_n = 1'b0;
        #H;
        q3.push_back({1'b1, 8'hA5, 16'd0, 8'hA5});
        q3.push_back({1'b1, 8'h7F, 16'd0, 8'h7F});
        q3.push_back({1'b1, 8'h7E, 16'd0, 8'h7E});
        q3.push_back({1'b1, 8'h7D, 16'd0, 8'h7D});
        q3.push_back({1'b1, 8'h7C, 16'd0, 8'h7C});
        spi(8'hA5, 8, 1'b1);
        #(2 * H);
        chk("m3_head_data", 32'(d3), 32'hA5);
        chk("m3_head_cmd", 32'(c3), 32'd1);
        spi(8'h7F, 8, 1'b1);
        spi(8'h7E, 8, 1'b1);
        spi(8'h7D, 8, 1'b1);
        @(negedge clock);
        fork
            spi(8'h7C, 8, 1'b1);
            begin
                #(15 * H);
                @(posedge clock);
                @(posedge clock);
                #1 ready3 = 1'b1;
                @(posedge clock);
                #1 ready3 = 1'b0;
            end
        join
        #(2 * H);
        chk("m3_no_ovf", 32'(ovf3), 32'd0);
        set_rdy(1'b1, 1'b1);
        drain("drain_m3");
        chk("m3_count", 32'(got3), 32'd5);
        chk("m3_fe", 32'(fec3), 32'd0);

`ifdef SPI_RX_STATS_EN
        chk("rx_words0", rxw0, 32'(words0));
        chk("drop_count0", 32'(drp0), 32'd3);
        chk("rx_words3", rxw3, 32'd5);
        chk("drop_count3", 32'(drp3), 32'd0);
`endif

        set_rdy(1'b0, 1'b1);
        send0(8'h7F);
        #(2 * H);
        chk("stall_valid", 32'(v0), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst2_valid", 32'(v0), 32'd0);
        chk("rst2_data", 32'(d0), 32'd0);
        chk("rst2_ovf", 32'(of0), 32'd0);
`ifdef SPI_RX_STATS_EN
        chk("rst2_rx_words", rxw0, 32'd0);
        chk("rst2_drops", 32'(drp0), 32'd0);
`endif
        set_rdy(1'b1, 1'b1);
        repeat (4) @(negedge clock);
        chk("final_q0", 32'(q0.size()), 32'd0);
        chk("final_q3", 32'(q3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
